// File: rtl/se_pkg.sv
// se_pkg: shared constants, effect ROM table, state type and helpers for
// the sound-effect scheduler.
package se_pkg;

   localparam int unsigned NUM_SE             = 4;
   localparam int unsigned ID_W               = $clog2(NUM_SE);
   localparam int unsigned ADDR_W             = 11;
   localparam int unsigned DATA_W             = 32;
   localparam int unsigned SAMPLE_DIV_DEFAULT = 2080;
   localparam int unsigned ROM_LAT_DEFAULT    = 2;

   // Effect layout in the shared sample ROM, indexed by effect id.
   localparam logic [NUM_SE-1:0][ADDR_W-1:0] SE_BASE =
      {11'd1242, 11'd942, 11'd430, 11'd0};
   localparam logic [NUM_SE-1:0][ADDR_W-1:0] SE_LEN =
      {11'd800, 11'd300, 11'd512, 11'd430};

   localparam logic [DATA_W-1:0] SE_DC_OFFSET = 32'd10000;
   localparam logic [DATA_W-1:0] SE_GAIN      = 32'd12000;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      WAIT  = 2'd2
   } se_state_e;

   // Effect ids; a higher id has higher priority.
   typedef enum logic [ID_W-1:0] {
      SE_MOVE  = 2'd0,
      SE_CLEAR = 2'd1,
      SE_DROP  = 2'd2,
      SE_OVER  = 2'd3
   } se_id_e;

   // Address of the final sample of an effect.
   function automatic logic [ADDR_W-1:0] se_last_addr(input logic [ID_W-1:0] id);
      return ADDR_W'(SE_BASE[id] + SE_LEN[id] - ADDR_W'(1));
   endfunction

   // Remove the DC offset and apply gain; wraps modulo 2^32 by design.
   function automatic logic [DATA_W-1:0] se_scale(input logic [DATA_W-1:0] q);
      return DATA_W'((q - SE_DC_OFFSET) * SE_GAIN);
   endfunction

endpackage

// File: rtl/se_scheduler_if.sv
// se_scheduler_if: trigger, ROM and codec-side signals of the scheduler.
//   trig        : per-effect request levels (game FSM -> scheduler)
//   rom_q       : sample ROM read data
//   rom_addr    : sample ROM read address
//   sound       : scaled sample to the codec
//   sample_tick : one-cycle pulse when sound updates
//   busy        : scheduler not idle
//   active_id   : effect currently playing
//   done        : one-cycle pulse when an effect completes
// slave = scheduler side, master = environment side.
interface se_scheduler_if;
   import se_pkg::*;

   logic [NUM_SE-1:0] trig;
   logic [DATA_W-1:0] rom_q;
   logic [ADDR_W-1:0] rom_addr;
   logic [DATA_W-1:0] sound;
   logic              sample_tick;
   logic              busy;
   logic [ID_W-1:0]   active_id;
   logic              done;

   modport master (
      output trig, rom_q,
      input  rom_addr, sound, sample_tick, busy, active_id, done
   );

   modport slave (
      input  trig, rom_q,
      output rom_addr, sound, sample_tick, busy, active_id, done
   );

endinterface

// File: rtl/se_req_latch.sv
// se_req_latch: rising-edge request capture, per-effect pending flags and
// highest-index priority encoder.
//   clk, resetn   : clock, async active-low reset
//   i_trig        : per-effect request levels
//   i_clr         : strobe, effect i_clr_id has been started
//   i_clr_id      : id whose pending flag is cleared
//   o_any_pend_c  : at least one effect pending (combinational from flags)
//   o_top_id_c    : highest pending id (combinational from flags)
module se_req_latch
   import se_pkg::*;
(
   input  logic              clk,
   input  logic              resetn,
   input  logic [NUM_SE-1:0] i_trig,
   input  logic              i_clr,
   input  logic [ID_W-1:0]   i_clr_id,
   output logic              o_any_pend_c,
   output logic [ID_W-1:0]   o_top_id_c
);

   logic [NUM_SE-1:0] r_trig_q;
   logic [NUM_SE-1:0] r_pend;
   logic [NUM_SE-1:0] w_edge;
   logic [NUM_SE-1:0] w_clr_mask;

   // Edge detect and one-hot clear mask.
   always_comb begin
      w_edge     = i_trig & ~r_trig_q;
      w_clr_mask = '0;
      if (i_clr) begin
         w_clr_mask[i_clr_id] = 1'b1;
      end
   end

   // A new edge overrides a simultaneous clear so that request is not lost.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_trig_q <= '0;
         r_pend   <= '0;
      end else begin
         r_trig_q <= i_trig;
         r_pend   <= (r_pend & ~w_clr_mask) | w_edge;
      end
   end

   // Highest set index wins.
   always_comb begin
      o_any_pend_c = |r_pend;
      o_top_id_c   = '0;
      for (int unsigned i = 0; i < NUM_SE; i++) begin
         if (r_pend[i]) begin
            o_top_id_c = ID_W'(i);
         end
      end
   end

endmodule

// File: rtl/se_scheduler.sv
// se_scheduler: arbitrates sound-effect requests onto one sample ROM and
// plays the selected effect at a fixed sample rate.
//   clk, resetn : clock, async active-low reset
//   bus (slave) : trig/rom_q in; rom_addr, sound, sample_tick, busy,
//                 active_id, done out (all registered)
// Parameters: SAMPLE_DIV clocks per sample (must exceed ROM_LAT+1),
//             ROM_LAT ROM read latency in clocks.
module se_scheduler
   import se_pkg::*;
#(
   parameter int unsigned SAMPLE_DIV = SAMPLE_DIV_DEFAULT,
   parameter int unsigned ROM_LAT    = ROM_LAT_DEFAULT
)(
   input  logic         clk,
   input  logic         resetn,
   se_scheduler_if.slave bus
);

   localparam int unsigned WAIT_CYC = SAMPLE_DIV - ROM_LAT - 1;
   localparam int unsigned CNT_W    = $clog2(SAMPLE_DIV);
   localparam logic [CNT_W-1:0] FETCH_LAST = CNT_W'(ROM_LAT);
   localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(WAIT_CYC - 1);

   se_state_e         r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic [ID_W-1:0]   r_active_id;
   logic [ADDR_W-1:0] r_rom_addr;
   logic [DATA_W-1:0] r_sound;
   logic              r_tick;
   logic              r_busy;
   logic              r_done;

   logic              w_any_pend;
   logic [ID_W-1:0]   w_top_id;
   logic              w_fetch_last;
   logic              w_boundary;
   logic              w_last_sample;
   logic              w_preempt;
   logic              w_start;

   se_req_latch u_req (
      .clk          (clk),
      .resetn       (resetn),
      .i_trig       (bus.trig),
      .i_clr        (w_start),
      .i_clr_id     (w_top_id),
      .o_any_pend_c (w_any_pend),
      .o_top_id_c   (w_top_id)
   );

   // Start decision: from IDLE on any request, or at a sample boundary when
   // an equal/higher request is pending or the current effect just ended.
   always_comb begin
      w_fetch_last  = (r_state == FETCH) && (r_cnt == FETCH_LAST);
      w_boundary    = (r_state == WAIT) && (r_cnt == WAIT_LAST);
      w_last_sample = (r_rom_addr == se_last_addr(r_active_id));
      w_preempt     = w_any_pend && (w_top_id >= r_active_id);
      w_start       = w_any_pend &&
                      ((r_state == IDLE) ||
                       (w_boundary && (w_preempt || w_last_sample)));
   end

   // Playback FSM with registered outputs.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_active_id <= '0;
         r_rom_addr  <= '0;
         r_sound     <= '0;
         r_tick      <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_tick <= 1'b0;
         r_done <= 1'b0;
         if (w_start) begin
            // A start at a boundary without preemption means natural completion.
            if ((r_state == WAIT) && !w_preempt) begin
               r_done <= 1'b1;
            end
            r_active_id <= w_top_id;
            r_rom_addr  <= SE_BASE[w_top_id];
            r_cnt       <= '0;
            r_busy      <= 1'b1;
            r_state     <= FETCH;
         end else begin
            case (r_state)
               IDLE: begin
                  r_busy <= 1'b0;
               end
               FETCH: begin
                  if (w_fetch_last) begin
                     r_sound <= se_scale(bus.rom_q);
                     r_tick  <= 1'b1;
                     r_cnt   <= '0;
                     r_state <= WAIT;
                  end else begin
                     r_cnt <= r_cnt + CNT_W'(1);
                  end
               end
               WAIT: begin
                  if (!w_boundary) begin
                     r_cnt <= r_cnt + CNT_W'(1);
                  end else if (w_last_sample) begin
                     r_done  <= 1'b1;
                     r_sound <= '0;
                     r_busy  <= 1'b0;
                     r_state <= IDLE;
                  end else begin
                     r_rom_addr <= r_rom_addr + ADDR_W'(1);
                     r_cnt      <= '0;
                     r_state    <= FETCH;
                  end
               end
               default: begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.rom_addr    = r_rom_addr;
   assign bus.sound       = r_sound;
   assign bus.sample_tick = r_tick;
   assign bus.busy        = r_busy;
   assign bus.active_id   = r_active_id;
   assign bus.done        = r_done;

endmodule

// File: tb/tb_se_scheduler.sv
// tb_se_scheduler: self-checking bench for se_scheduler with SAMPLE_DIV=16,
// ROM_LAT=2 and a ROM returning addr+10000 (so sound = addr*12000).
module tb_se_scheduler;
   import se_pkg::*;

   localparam int unsigned SD      = 16;
   localparam int unsigned RL      = 2;
   localparam int          MAX_ERR = 40;

   logic clk    = 1'b0;
   logic resetn = 1'b0;

   se_scheduler_if bus();

   se_scheduler #(.SAMPLE_DIV(SD), .ROM_LAT(RL)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   // Two-stage ROM: registered address, registered data.
   logic [ADDR_W-1:0] rom_a;
   always @(posedge clk) begin
      rom_a      <= bus.rom_addr;
      bus.rom_q  <= 32'(rom_a) + 32'd10000;
   end

   // Effect table kept independently of the design package.
   int base_t [4] = '{0, 430, 942, 1242};
   int len_t  [4] = '{430, 512, 300, 800};

   int n_chk = 0;
   int n_err = 0;
   int g_ticks = 0;
   int g_dones = 0;

   // Reference model state: which effect plays, which sample, and the
   // absolute cycle numbers of the next tick and next sample boundary.
   longint     cyc;
   logic [3:0] m_trig_q;
   logic [3:0] m_pend;
   bit         m_busy, m_tick, m_done;
   int         m_id, m_off;
   longint     m_tick_at, m_bnd;
   logic [31:0] m_sound;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s act=%0d exp=%0d", name, act, exp);
      end
   endtask

   function automatic int top_pend(input logic [3:0] p);
      int r;
      r = -1;
      for (int i = 0; i < 4; i++) if (p[i]) r = i;
      return r;
   endfunction

   task automatic model_reset();
      cyc = 0; m_trig_q = '0; m_pend = '0;
      m_busy = 0; m_tick = 0; m_done = 0;
      m_id = 0; m_off = 0; m_tick_at = -1; m_bnd = -1;
      m_sound = '0;
   endtask

   task automatic m_start(input int p);
      m_pend[p] = 1'b0;
      m_id      = p;
      m_off     = 0;
      m_busy    = 1;
      m_tick_at = cyc + RL + 1;
      m_bnd     = cyc + SD;
   endtask

   // Advance the model by one clock edge with trig value t sampled there.
   task automatic model_edge(input logic [3:0] t);
      logic [3:0] e;
      int p;
      cyc++;
      e = t & ~m_trig_q;
      m_trig_q = t;
      m_tick = 0;
      m_done = 0;
      p = top_pend(m_pend);
      if (!m_busy) begin
         if (p >= 0) m_start(p);
      end else if (cyc == m_bnd) begin
         if (p >= m_id) m_start(p);
         else if (m_off == len_t[m_id] - 1) begin
            m_done = 1;
            if (p >= 0) m_start(p);
            else begin
               m_busy  = 0;
               m_sound = '0;
            end
         end else begin
            m_off++;
            m_tick_at = cyc + RL + 1;
            m_bnd     = cyc + SD;
         end
      end else if (cyc == m_tick_at) begin
         m_tick  = 1;
         m_sound = 32'((base_t[m_id] + m_off) * 12000);
      end
      m_pend = m_pend | e;
   endtask

   task automatic check_model();
      logic ok;
      ok = (bus.sound === m_sound) && (bus.sample_tick === m_tick) &&
           (bus.busy === m_busy) && (bus.done === m_done);
      if (m_busy)
         ok = ok && (32'(bus.rom_addr) === 32'(base_t[m_id] + m_off)) &&
                    (32'(bus.active_id) === 32'(m_id));
      n_chk++;
      if (!ok) begin
         n_err++;
         $display("FAIL model cyc=%0d act sound=%0d tick=%b busy=%b done=%b addr=%0d id=%0d exp sound=%0d tick=%b busy=%b done=%b addr=%0d id=%0d",
                  cyc, bus.sound, bus.sample_tick, bus.busy, bus.done, bus.rom_addr, bus.active_id,
                  m_sound, m_tick, m_busy, m_done, base_t[m_id] + m_off, m_id);
      end
   endtask

   // One clock: drive trig at negedge, sample #1 after posedge.
   task automatic step(input logic [3:0] t);
      @(negedge clk);
      bus.trig = t;
      @(posedge clk);
      #1;
      model_edge(t);
      check_model();
      g_ticks += int'(bus.sample_tick);
      g_dones += int'(bus.done);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      bus.trig = '0;
      resetn   = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      resetn = 1'b1;
   endtask

   task automatic run_to_idle(input int max_cyc);
      int n;
      n = 0;
      while ((m_busy || m_pend != 0) && n < max_cyc && n_err <= MAX_ERR) begin
         step(4'b0000);
         n++;
      end
      n_chk++;
      if (n >= max_cyc) begin
         n_err++;
         $display("FAIL run_to_idle act=%0d cycles exp<%0d", n, max_cyc);
      end
   endtask

   typedef struct {
      logic [3:0]  trig;
      int          id;
      int          addr;
      logic [31:0] snd;
   } vec_t;

   vec_t vt [9];

   initial begin
      #1500000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1);
   end

   initial begin
      int n;
      logic [3:0] t;

      vt[0] = '{4'b0001, 0, 0,    32'd0};
      vt[1] = '{4'b0010, 1, 430,  32'd5160000};
      vt[2] = '{4'b0100, 2, 942,  32'd11304000};
      vt[3] = '{4'b1000, 3, 1242, 32'd14904000};
      vt[4] = '{4'b0011, 1, 430,  32'd5160000};
      vt[5] = '{4'b0101, 2, 942,  32'd11304000};
      vt[6] = '{4'b1111, 3, 1242, 32'd14904000};
      vt[7] = '{4'b0110, 2, 942,  32'd11304000};
      vt[8] = '{4'b1001, 3, 1242, 32'd14904000};

      bus.trig = '0;
      resetn   = 1'b0;
      model_reset();

      // Reset state.
      repeat (2) @(posedge clk);
      #1;
      chk("rst_sound", bus.sound, 32'd0);
      chk("rst_addr", 32'(bus.rom_addr), 32'd0);
      chk("rst_tick", 32'(bus.sample_tick), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_id", 32'(bus.active_id), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);

      // Start latency and priority from idle.
      foreach (vt[i]) begin
         apply_reset();
         step(vt[i].trig);
         step(4'b0000);
         chk("vec_busy", 32'(bus.busy), 32'd1);
         chk("vec_addr", 32'(bus.rom_addr), 32'(vt[i].addr));
         chk("vec_id", 32'(bus.active_id), 32'(vt[i].id));
         step(4'b0000);
         step(4'b0000);
         chk("vec_pre_tick", 32'(bus.sample_tick), 32'd0);
         step(4'b0000);
         chk("vec_tick", 32'(bus.sample_tick), 32'd1);
         chk("vec_sound", bus.sound, vt[i].snd);
      end

      // Single full play of effect 0.
      apply_reset();
      g_ticks = 0; g_dones = 0;
      step(4'b0001);
      run_to_idle(430 * SD + 100);
      chk("single_ticks", 32'(g_ticks), 32'd430);
      chk("single_dones", 32'(g_dones), 32'd1);
      chk("single_busy", 32'(bus.busy), 32'd0);
      chk("single_sound", bus.sound, 32'd0);

      // Preemption of effect 0 by effect 3 at address 100.
      apply_reset();
      g_dones = 0;
      step(4'b0001);
      n = 0;
      while (!(m_busy && m_off == 100) && n < 3000) begin step(4'b0000); n++; end
      chk("pre_addr100", 32'(bus.rom_addr), 32'd100);
      step(4'b1000);
      n = 0;
      while (bus.rom_addr === 11'd100 && n < 2 * SD) begin step(4'b0000); n++; end
      chk("pre_new_addr", 32'(bus.rom_addr), 32'd1242);
      chk("pre_new_id", 32'(bus.active_id), 32'd3);
      n = 0;
      while (bus.sample_tick !== 1'b1 && n < 2 * SD) begin step(4'b0000); n++; end
      chk("pre_sound", bus.sound, 32'd14904000);
      run_to_idle(800 * SD + 100);
      chk("pre_dones", 32'(g_dones), 32'd1);
      chk("pre_busy", 32'(bus.busy), 32'd0);

      // Queueing: effect 1 then effect 0, no idle gap.
      apply_reset();
      g_ticks = 0; g_dones = 0;
      step(4'b0011);
      n = 0;
      while (bus.done !== 1'b1 && n < 512 * SD + 100) begin step(4'b0000); n++; end
      chk("q_done", 32'(bus.done), 32'd1);
      chk("q_ticks_first", 32'(g_ticks), 32'd512);
      chk("q_next_addr", 32'(bus.rom_addr), 32'd0);
      chk("q_next_id", 32'(bus.active_id), 32'd0);
      chk("q_no_gap", 32'(bus.busy), 32'd1);
      g_ticks = 0; g_dones = 0;
      run_to_idle(430 * SD + 100);
      chk("q_ticks_second", 32'(g_ticks), 32'd430);
      chk("q_dones_second", 32'(g_dones), 32'd1);

      // Re-trigger of effect 2 mid-play.
      apply_reset();
      g_dones = 0;
      step(4'b0100);
      n = 0;
      while (m_off < 50 && n < 2000) begin step(4'b0000); n++; end
      step(4'b0100);
      n = 0;
      while (bus.rom_addr !== 11'd942 && n < 2 * SD) begin step(4'b0000); n++; end
      chk("rt_addr", 32'(bus.rom_addr), 32'd942);
      chk("rt_no_done", 32'(g_dones), 32'd0);
      g_ticks = 0;
      run_to_idle(300 * SD + 100);
      chk("rt_ticks", 32'(g_ticks), 32'd300);
      chk("rt_dones", 32'(g_dones), 32'd1);

      // Held trigger gives exactly one play.
      apply_reset();
      g_ticks = 0; g_dones = 0;
      for (int i = 0; i < 2000; i++) step(4'b0010);
      run_to_idle(512 * SD + 100);
      chk("held_ticks", 32'(g_ticks), 32'd512);
      chk("held_dones", 32'(g_dones), 32'd1);

      // Asynchronous reset between edges during WAIT.
      apply_reset();
      step(4'b0100);
      n = 0;
      while (bus.sample_tick !== 1'b1 && n < 40) begin step(4'b0000); n++; end
      step(4'b0000);
      step(4'b0000);
      step(4'b0000);
      chk("ar_pre_busy", 32'(bus.busy), 32'd1);
      #2;
      resetn = 1'b0;
      #1;
      chk("ar_sound", bus.sound, 32'd0);
      chk("ar_addr", 32'(bus.rom_addr), 32'd0);
      chk("ar_busy", 32'(bus.busy), 32'd0);
      chk("ar_id", 32'(bus.active_id), 32'd0);
      bus.trig = '0;
      model_reset();
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      for (int i = 0; i < 40; i++) step(4'b0000);
      chk("ar_after_busy", 32'(bus.busy), 32'd0);

      // Random trigger activity against the model.
      apply_reset();
      t = '0;
      for (int i = 0; i < 10000 && n_err <= MAX_ERR; i++) begin
         for (int b = 0; b < 4; b++)
            if ($urandom_range(0, 399) == 0) t[b] = ~t[b];
         step(t);
      end

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
